// File: rtl/boot_pkg.sv
// Shared types for the boot image sequencer.
// I2C byte-master opcodes and the sequencer state encoding.
package boot_pkg;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } i2c_op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START1,
        ST_DEVW,
        ST_ADDRH,
        ST_ADDRL,
        ST_START2,
        ST_DEVR,
        ST_RDHI,
        ST_RDLO,
        ST_WRAM,
        ST_STOP,
        ST_RETRY,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    function automatic i2c_op_t op_of(boot_state_t s);
        case (s)
            ST_DEVW, ST_ADDRH,
            ST_ADDRL, ST_DEVR: return OP_WRITE;
            ST_RDHI, ST_RDLO:  return OP_READ;
            ST_STOP:           return OP_STOP;
            default:           return OP_START;
        endcase
    endfunction

    function automatic logic is_cmd(boot_state_t s);
        case (s)
            ST_START1, ST_DEVW, ST_ADDRH,
            ST_ADDRL, ST_START2, ST_DEVR,
            ST_RDHI, ST_RDLO, ST_STOP: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_write(boot_state_t s);
        return op_of(s) == OP_WRITE;
    endfunction

endpackage

// File: rtl/boot_word_pack.sv
// Packs a high byte and a low byte into one 16-bit word.
// The valid pulse follows the low-byte strobe by one cycle.
module boot_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        hi_stb,
    input  logic        lo_stb,
    output logic [15:0] word,
    output logic        valid
);

    logic [7:0] hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= 8'h00;
            word  <= 16'h0000;
            valid <= 1'b0;
        end else begin
            valid <= lo_stb;
            if (hi_stb)
                hi <= data;
            if (lo_stb)
                word <= {hi, data};
        end
    end

endmodule

// File: rtl/boot_seq_ctrl.sv
// Copies the boot image from an I2C EEPROM into instruction RAM,
// then releases the CPU from reset.
module boot_seq_ctrl
    import boot_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'b1010000,
    parameter logic [15:0] EE_BASE    = 16'h0000,
    parameter int          WORD_COUNT = 10,
    parameter logic [13:0] RAM_BASE   = 14'h0000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_wdata,
    output logic        cmd_nack,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_nack,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic        ram_bank,
    output logic [15:0] ram_wdata,
    output logic        boot_complete,
    output logic        boot_error,
    output logic        cpu_rst_n
);

    localparam int RW =
        (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [14:0] LAST_IDX =
        15'(WORD_COUNT - 1);

    boot_state_t state;
    boot_state_t nxt;
    logic        adv;
    logic        pend;
    logic        nacked;
    logic [RW-1:0] retry_cnt;
    logic [14:0] word_idx;
    logic        last;
    logic        retry_max;
    logic        wr_nack;
    logic [13:0] ram_sum;

    assign last      = word_idx == LAST_IDX;
    assign retry_max = retry_cnt == RW'(MAX_RETRY);
    assign wr_nack   = is_write(state) && rsp_nack;
    assign ram_sum   = RAM_BASE + word_idx[13:0];

    function automatic logic [7:0] wdata_of(boot_state_t s);
        case (s)
            ST_DEVW:  return {DEV_ADDR, I2C_WR};
            ST_ADDRH: return EE_BASE[15:8];
            ST_ADDRL: return EE_BASE[7:0];
            ST_DEVR:  return {DEV_ADDR, I2C_RD};
            default:  return 8'h00;
        endcase
    endfunction

    // Command states advance only on the response to their own command.
    always_comb begin
        nxt = state;
        adv = 1'b0;
        unique case (state)
            ST_IDLE: begin
                adv = 1'b1;
                nxt = ST_START1;
            end
            ST_WRAM: begin
                adv = 1'b1;
                nxt = last ? ST_STOP : ST_RDHI;
            end
            ST_RETRY: begin
                adv = 1'b1;
                nxt = ST_START1;
            end
            ST_DONE, ST_ERR: begin
                adv = 1'b0;
            end
            default: begin
                if (pend && rsp_valid) begin
                    adv = 1'b1;
                    case (state)
                        ST_START1: nxt = ST_DEVW;
                        ST_DEVW:   nxt = wr_nack ? ST_STOP : ST_ADDRH;
                        ST_ADDRH:  nxt = wr_nack ? ST_STOP : ST_ADDRL;
                        ST_ADDRL:  nxt = wr_nack ? ST_STOP : ST_START2;
                        ST_START2: nxt = ST_DEVR;
                        ST_DEVR:   nxt = wr_nack ? ST_STOP : ST_RDHI;
                        ST_RDHI:   nxt = ST_RDLO;
                        ST_RDLO:   nxt = ST_WRAM;
                        ST_STOP: begin
                            if (!nacked)
                                nxt = ST_DONE;
                            else if (retry_max)
                                nxt = ST_ERR;
                            else
                                nxt = ST_RETRY;
                        end
                        default:   nxt = state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cmd_valid     <= 1'b0;
            cmd_op        <= 2'd0;
            cmd_wdata     <= 8'h00;
            cmd_nack      <= 1'b0;
            pend          <= 1'b0;
            nacked        <= 1'b0;
            retry_cnt     <= '0;
            word_idx      <= '0;
            ram_addr      <= 13'h0000;
            ram_bank      <= 1'b0;
            boot_complete <= 1'b0;
            boot_error    <= 1'b0;
            cpu_rst_n     <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                pend      <= 1'b1;
            end
            if (adv) begin
                state     <= nxt;
                pend      <= 1'b0;
                cmd_valid <= is_cmd(nxt);
                cmd_op    <= op_of(nxt);
                cmd_wdata <= wdata_of(nxt);
                cmd_nack  <= (nxt == ST_RDLO) && last;
                if (wr_nack)
                    nacked <= 1'b1;
                if (nxt == ST_WRAM)
                    {ram_bank, ram_addr} <= ram_sum;
                if (state == ST_WRAM && !last)
                    word_idx <= word_idx + 15'd1;
                if (state == ST_RETRY) begin
                    word_idx  <= '0;
                    retry_cnt <= retry_cnt + 1'b1;
                    nacked    <= 1'b0;
                end
                if (nxt == ST_DONE) begin
                    boot_complete <= 1'b1;
                    cpu_rst_n     <= 1'b1;
                end
                if (nxt == ST_ERR)
                    boot_error <= 1'b1;
            end
        end
    end

    boot_word_pack u_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (rsp_rdata),
        .hi_stb (adv && state == ST_RDHI),
        .lo_stb (adv && state == ST_RDLO),
        .word   (ram_wdata),
        .valid  (ram_we)
    );

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for boot_seq_ctrl with a zero/fixed-wait byte master
// model and an EEPROM returning 12 34 56 78 ...
module tb_boot_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_wdata;
    logic        cmd_nack;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_rdata = 8'h00;
    logic        rsp_nack = 1'b0;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic        ram_bank;
    logic [15:0] ram_wdata;
    logic        boot_complete;
    logic        boot_error;
    logic        cpu_rst_n;

    logic        w_cmd_valid;
    logic [1:0]  w_cmd_op;
    logic [7:0]  w_cmd_wdata;
    logic        w_cmd_nack;
    logic        w_ram_we;
    logic [12:0] w_ram_addr;
    logic        w_ram_bank;
    logic [15:0] w_ram_wdata;
    logic        w_boot_complete;
    logic        w_boot_error;
    logic        w_cpu_rst_n;

    always #5 clk = ~clk;

    boot_seq_ctrl #(.WORD_COUNT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_bank(ram_bank),
        .ram_wdata(ram_wdata), .boot_complete(boot_complete),
        .boot_error(boot_error), .cpu_rst_n(cpu_rst_n)
    );

    // Runs in lockstep with u_dut on the same bus; only RAM addresses differ.
    boot_seq_ctrl #(.WORD_COUNT(2), .RAM_BASE(14'h3FFF)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(w_cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(w_cmd_op), .cmd_wdata(w_cmd_wdata), .cmd_nack(w_cmd_nack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .ram_we(w_ram_we), .ram_addr(w_ram_addr), .ram_bank(w_ram_bank),
        .ram_wdata(w_ram_wdata), .boot_complete(w_boot_complete),
        .boot_error(w_boot_error), .cpu_rst_n(w_cpu_rst_n)
    );

    localparam logic [10:0] EXP_SEQ [11] = '{
        {2'd0, 8'h00, 1'b0}, {2'd1, 8'hA0, 1'b0},
        {2'd1, 8'h00, 1'b0}, {2'd1, 8'h00, 1'b0},
        {2'd0, 8'h00, 1'b0}, {2'd1, 8'hA1, 1'b0},
        {2'd2, 8'h00, 1'b0}, {2'd2, 8'h00, 1'b0},
        {2'd2, 8'h00, 1'b0}, {2'd2, 8'h00, 1'b1},
        {2'd3, 8'h00, 1'b0}
    };
    localparam logic [10:0] C_START = {2'd0, 8'h00, 1'b0};
    localparam logic [10:0] C_DEVW  = {2'd1, 8'hA0, 1'b0};
    localparam logic [10:0] C_STOP  = {2'd3, 8'h00, 1'b0};

    int checks = 0;
    int passed = 0;

    int stall_cycles = 0;
    int nack_mode = 0;
    int wait_cnt = 0;
    int rd_ptr = 0;
    int devw_seen = 0;
    bit pending = 1'b0;
    logic [7:0] nx_rdata = 8'h00;
    logic       nx_nack = 1'b0;
    logic [10:0] cmd_log [$];
    logic [29:0] ram_log [$];
    logic [29:0] wrap_log [$];

    // Byte master + EEPROM model; everything clears while rst_n is low.
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            rsp_rdata = 8'h00;
            cmd_ready = 1'b0;
            pending   = 1'b0;
            wait_cnt  = 0;
            rd_ptr    = 0;
            devw_seen = 0;
            cmd_log.delete();
            ram_log.delete();
            wrap_log.delete();
        end else begin
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (pending) begin
                rsp_valid = 1'b1;
                rsp_rdata = nx_rdata;
                rsp_nack  = nx_nack;
                pending   = 1'b0;
            end
            if (ram_we)
                ram_log.push_back({ram_bank, ram_addr, ram_wdata});
            if (w_ram_we)
                wrap_log.push_back({w_ram_bank, w_ram_addr, w_ram_wdata});
            cmd_ready = 1'b0;
            if (cmd_valid) begin
                if (wait_cnt < stall_cycles) begin
                    wait_cnt++;
                end else begin
                    cmd_ready = 1'b1;
                    wait_cnt  = 0;
                    pending   = 1'b1;
                    nx_nack   = 1'b0;
                    case (cmd_op)
                        2'd0: begin
                            rd_ptr = 0;
                            cmd_log.push_back({2'd0, 8'h00, 1'b0});
                        end
                        2'd1: begin
                            if (cmd_wdata == 8'hA0) begin
                                nx_nack = (nack_mode == 2) ||
                                          (nack_mode == 1 && devw_seen == 0);
                                devw_seen++;
                            end
                            cmd_log.push_back({2'd1, cmd_wdata, 1'b0});
                        end
                        2'd2: begin
                            nx_rdata = 8'(8'h12 + 8'h22 * rd_ptr);
                            rd_ptr++;
                            cmd_log.push_back({2'd2, 8'h00, cmd_nack});
                        end
                        default: begin
                            cmd_log.push_back({2'd3, 8'h00, 1'b0});
                        end
                    endcase
                end
            end
        end
    end

    task automatic start_run(input int stall, input int nmode);
        rst_n = 1'b0;
        stall_cycles = stall;
        nack_mode = nmode;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (cmd_valid !== 1'b0)
            $display("FAIL rst_cmd_valid got %b want 0", cmd_valid);
        else passed++;
        checks++;
        if (ram_we !== 1'b0)
            $display("FAIL rst_ram_we got %b want 0", ram_we);
        else passed++;
        checks++;
        if ({boot_complete, boot_error, cpu_rst_n} !== 3'b000)
            $display("FAIL rst_status got %b%b%b want 000",
                     boot_complete, boot_error, cpu_rst_n);
        else passed++;
        checks++;
        if ({ram_bank, ram_addr, ram_wdata} !== 30'h0)
            $display("FAIL rst_ram_bus got %h want 0",
                     {ram_bank, ram_addr, ram_wdata});
        else passed++;
        checks++;
        if ({cmd_op, cmd_wdata, cmd_nack} !== 11'h0)
            $display("FAIL rst_cmd_bus got %h want 0",
                     {cmd_op, cmd_wdata, cmd_nack});
        else passed++;
    endtask

    task automatic test_basic();
        int n = 0;
        int ncmd;
        start_run(0, 0);
        @(posedge clk);
        #2;
        checks++;
        if ({cmd_valid, cmd_op} !== 3'b100)
            $display("FAIL basic_autostart got %b%b want 1 00",
                     cmd_valid, cmd_op);
        else passed++;
        while (!boot_complete && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (boot_complete !== 1'b1)
            $display("FAIL basic_done got %b want 1", boot_complete);
        else passed++;
        checks++;
        if ({cpu_rst_n, boot_error} !== 2'b10)
            $display("FAIL basic_cpu got %b%b want 10", cpu_rst_n, boot_error);
        else passed++;
        checks++;
        if (cmd_log.size() != 11)
            $display("FAIL basic_ncmd got %0d want 11", cmd_log.size());
        else passed++;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (cmd_log[i] !== EXP_SEQ[i])
                $display("FAIL basic_cmd%0d got %h want %h",
                         i, cmd_log[i], EXP_SEQ[i]);
            else passed++;
        end
        checks++;
        if (ram_log.size() != 2 || ram_log[0] !== {1'b0, 13'h0000, 16'h1234} ||
            ram_log[1] !== {1'b0, 13'h0001, 16'h5678})
            $display("FAIL basic_ram got n=%0d %h %h want 00001234 00015678",
                     ram_log.size(), ram_log[0], ram_log[1]);
        else passed++;
        checks++;
        if (wrap_log.size() != 2 ||
            wrap_log[0] !== {1'b1, 13'h1FFF, 16'h1234} ||
            wrap_log[1] !== {1'b0, 13'h0000, 16'h5678})
            $display("FAIL wrap_ram got n=%0d %h %h want 3fff1234 00005678",
                     wrap_log.size(), wrap_log[0], wrap_log[1]);
        else passed++;
        checks++;
        if (w_boot_complete !== 1'b1)
            $display("FAIL wrap_done got %b want 1", w_boot_complete);
        else passed++;
        ncmd = cmd_log.size();
        repeat (20) @(posedge clk);
        #2;
        checks++;
        if (cmd_log.size() != ncmd || boot_complete !== 1'b1 || cmd_valid !== 1'b0)
            $display("FAIL basic_absorb got n=%0d done=%b valid=%b want n=%0d 1 0",
                     cmd_log.size(), boot_complete, cmd_valid, ncmd);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        int stable = 0;
        bit prev = 1'b0;
        logic [10:0] held = '0;
        start_run(5, 0);
        while (!boot_complete && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
            if (cmd_valid) begin
                if (prev) begin
                    stable++;
                    checks++;
                    if ({cmd_op, cmd_wdata, cmd_nack} !== held)
                        $display("FAIL bp_stable got %h want %h",
                                 {cmd_op, cmd_wdata, cmd_nack}, held);
                    else passed++;
                end else begin
                    held = {cmd_op, cmd_wdata, cmd_nack};
                end
            end
            prev = cmd_valid;
        end
        checks++;
        if (stable != 55)
            $display("FAIL bp_stall_cycles got %0d want 55", stable);
        else passed++;
        checks++;
        if (boot_complete !== 1'b1 || cpu_rst_n !== 1'b1)
            $display("FAIL bp_done got %b%b want 11", boot_complete, cpu_rst_n);
        else passed++;
        checks++;
        if (cmd_log.size() != 11)
            $display("FAIL bp_ncmd got %0d want 11", cmd_log.size());
        else passed++;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (cmd_log[i] !== EXP_SEQ[i])
                $display("FAIL bp_cmd%0d got %h want %h",
                         i, cmd_log[i], EXP_SEQ[i]);
            else passed++;
        end
        checks++;
        if (ram_log.size() != 2 || ram_log[0] !== {1'b0, 13'h0000, 16'h1234} ||
            ram_log[1] !== {1'b0, 13'h0001, 16'h5678})
            $display("FAIL bp_ram got n=%0d %h %h want 00001234 00015678",
                     ram_log.size(), ram_log[0], ram_log[1]);
        else passed++;
    endtask

    task automatic test_retry();
        int n = 0;
        start_run(0, 1);
        while (!boot_complete && !boot_error && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if ({boot_complete, boot_error, cpu_rst_n} !== 3'b101)
            $display("FAIL retry_status got %b%b%b want 101",
                     boot_complete, boot_error, cpu_rst_n);
        else passed++;
        checks++;
        if (cmd_log.size() != 14)
            $display("FAIL retry_ncmd got %0d want 14", cmd_log.size());
        else passed++;
        checks++;
        if (cmd_log[0] !== C_START || cmd_log[1] !== C_DEVW || cmd_log[2] !== C_STOP)
            $display("FAIL retry_abort got %h %h %h want %h %h %h",
                     cmd_log[0], cmd_log[1], cmd_log[2], C_START, C_DEVW, C_STOP);
        else passed++;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (cmd_log[3 + i] !== EXP_SEQ[i])
                $display("FAIL retry_cmd%0d got %h want %h",
                         i, cmd_log[3 + i], EXP_SEQ[i]);
            else passed++;
        end
        checks++;
        if (ram_log.size() != 2 || ram_log[1] !== {1'b0, 13'h0001, 16'h5678})
            $display("FAIL retry_ram got n=%0d last=%h want 2 00015678",
                     ram_log.size(), ram_log[1]);
        else passed++;
    endtask

    task automatic test_persistent_nack();
        int n = 0;
        int ncmd;
        start_run(0, 2);
        while (!boot_error && !boot_complete && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if ({boot_error, boot_complete, cpu_rst_n} !== 3'b100)
            $display("FAIL err_status got %b%b%b want 100",
                     boot_error, boot_complete, cpu_rst_n);
        else passed++;
        checks++;
        if (cmd_log.size() != 12)
            $display("FAIL err_ncmd got %0d want 12", cmd_log.size());
        else passed++;
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (cmd_log[3*a] !== C_START || cmd_log[3*a+1] !== C_DEVW ||
                cmd_log[3*a+2] !== C_STOP)
                $display("FAIL err_attempt%0d got %h %h %h want %h %h %h", a,
                         cmd_log[3*a], cmd_log[3*a+1], cmd_log[3*a+2],
                         C_START, C_DEVW, C_STOP);
            else passed++;
        end
        ncmd = cmd_log.size();
        repeat (20) @(posedge clk);
        #2;
        checks++;
        if (ram_log.size() != 0 || wrap_log.size() != 0)
            $display("FAIL err_ram_we got %0d writes want 0", ram_log.size());
        else passed++;
        checks++;
        if (cmd_log.size() != ncmd || boot_error !== 1'b1 || cpu_rst_n !== 1'b0)
            $display("FAIL err_absorb got n=%0d err=%b cpu=%b want n=%0d 1 0",
                     cmd_log.size(), boot_error, cpu_rst_n, ncmd);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start_run(0, 0);
        while (!(cmd_valid && cmd_op == 2'd2 && cmd_log.size() == 7) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (!(cmd_valid === 1'b1 && cmd_op === 2'd2))
            $display("FAIL mid_reach_rdlo got valid=%b op=%0d want 1 2",
                     cmd_valid, cmd_op);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cpu_rst_n !== 1'b0)
            $display("FAIL mid_async got valid=%b cpu=%b want 0 0",
                     cmd_valid, cpu_rst_n);
        else passed++;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        while (!boot_complete && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (boot_complete !== 1'b1 || cmd_log.size() != 11)
            $display("FAIL mid_restart got done=%b n=%0d want 1 11",
                     boot_complete, cmd_log.size());
        else passed++;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (cmd_log[i] !== EXP_SEQ[i])
                $display("FAIL mid_cmd%0d got %h want %h",
                         i, cmd_log[i], EXP_SEQ[i]);
            else passed++;
        end
        checks++;
        if (ram_log.size() != 2 || ram_log[0] !== {1'b0, 13'h0000, 16'h1234})
            $display("FAIL mid_ram got n=%0d %h want 2 00001234",
                     ram_log.size(), ram_log[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_retry();
        test_persistent_nack();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
